// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, retry counter width
// and a saturating increment helper.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StWaitLock = 3'd1,
    StRelease  = 3'd2,
    StGap      = 3'd3,
    StRun      = 3'd4
  } seq_state_e;

  localparam int unsigned RetryW = 8;

  function automatic logic [RetryW-1:0] sat_inc(input logic [RetryW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level signal; both flops clear
// on the asynchronous active-high reset.
module bit_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: holds all domains in reset, waits for a stable PLL lock,
// then releases the domains one at a time, re-sequencing on lock loss or software request.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned STAGE_GAP    = 8
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  pll_locked_i,
  input  logic                  sw_rst_req_i,
  input  logic [NUM_STAGES-1:0] stage_ready_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  seq_done_o,
  output logic                  lock_err_o,
  output logic [RetryW-1:0]     retry_cnt_o,
  output logic [2:0]            state_o
);

  localparam int unsigned HoldW   = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned StableW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned WaitW   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned GapW    = $clog2(STAGE_GAP + 1);
  localparam int unsigned IdxW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [HoldW-1:0]   HoldLast   = HoldW'(HOLD_CYCLES - 1);
  localparam logic [StableW-1:0] StableLast = StableW'(LOCK_STABLE - 1);
  localparam logic [WaitW-1:0]   WaitLast   = WaitW'(LOCK_TIMEOUT - 1);
  localparam logic [GapW-1:0]    GapLast    = GapW'(STAGE_GAP - 1);
  localparam logic [IdxW-1:0]    IdxLast    = IdxW'(NUM_STAGES - 1);

  logic lock_s;

  seq_state_e             state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [StableW-1:0]     stable_cnt_q, stable_cnt_d;
  logic [WaitW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [GapW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [NUM_STAGES-1:0]  stage_rst_q, stage_rst_d;
  logic                   lock_err_q, lock_err_d;
  logic [RetryW-1:0]      retry_q, retry_d;
  logic                   count_retry;

  bit_sync u_lock_sync (
    .clk_i (clk_i),
    .rst_i (async_rst_i),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q      <= StHold;
      idx_q        <= '0;
      hold_cnt_q   <= '0;
      stable_cnt_q <= '0;
      wait_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      stage_rst_q  <= '1;
      lock_err_q   <= 1'b0;
      retry_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_cnt_q   <= hold_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      stage_rst_q  <= stage_rst_d;
      lock_err_q   <= lock_err_d;
      retry_q      <= retry_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hold_cnt_d   = hold_cnt_q;
    stable_cnt_d = stable_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    stage_rst_d  = stage_rst_q;
    lock_err_d   = lock_err_q;
    retry_d      = retry_q;
    count_retry  = 1'b0;

    unique case (state_q)
      StHold: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == HoldLast) begin
          state_d = StWaitLock;
        end
      end
      StWaitLock: begin
        wait_cnt_d   = wait_cnt_q + 1'b1;
        stable_cnt_d = lock_s ? stable_cnt_q + 1'b1 : '0;
        if (lock_s && (stable_cnt_q == StableLast)) begin
          state_d = StRelease;
          idx_d   = '0;
        end else if (wait_cnt_q == WaitLast) begin
          state_d     = StHold;
          lock_err_d  = 1'b1;
          count_retry = 1'b1;
        end else if (sw_rst_req_i) begin
          state_d = StHold;
        end
      end
      StRelease: begin
        if (stage_ready_i[idx_q]) begin
          state_d = StGap;
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GapLast) begin
          if (idx_q == IdxLast) begin
            state_d = StRun;
          end else begin
            state_d = StRelease;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StHold;
      end
    endcase

    // Once released, lock loss aborts the sequence and is counted; a concurrent
    // software request is folded into the lock-loss case.
    if (state_q inside {StRelease, StGap, StRun}) begin
      if (!lock_s) begin
        state_d     = StHold;
        count_retry = 1'b1;
      end else if (sw_rst_req_i) begin
        state_d = StHold;
      end
    end

    if (state_d != state_q) begin
      hold_cnt_d   = '0;
      stable_cnt_d = '0;
      wait_cnt_d   = '0;
      gap_cnt_d    = '0;
    end

    if (count_retry) begin
      retry_d = sat_inc(retry_q);
    end

    // Reset outputs are registered alongside the state so they change in the same cycle.
    if (state_d == StHold) begin
      stage_rst_d = '1;
    end else if (state_d == StRelease) begin
      stage_rst_d[idx_d] = 1'b0;
    end
  end

  assign stage_rst_o = stage_rst_q;
  assign seq_done_o  = (state_q == StRun);
  assign lock_err_o  = lock_err_q;
  assign retry_cnt_o = retry_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: power-up vector table plus hand-written
// sequences for lock loss, software request, stalled stage, lock glitch and timeout.
module tb_reset_sequencer;

  localparam logic [2:0] SH = 3'd0;
  localparam logic [2:0] SW = 3'd1;
  localparam logic [2:0] SR = 3'd2;
  localparam logic [2:0] SG = 3'd3;
  localparam logic [2:0] SN = 3'd4;

  logic       clk        = 1'b0;
  logic       async_rst  = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] ready_en   = 4'hF;
  logic [3:0] stage_ready;
  logic [3:0] stage_rst;
  logic       seq_done;
  logic       lock_err;
  logic [7:0] retry_cnt;
  logic [2:0] state;

  // Each domain acknowledges as soon as its reset is deasserted, unless masked off.
  assign stage_ready = ~stage_rst & ready_en;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk_i         (clk),
    .async_rst_i   (async_rst),
    .pll_locked_i  (pll_locked),
    .sw_rst_req_i  (sw_rst_req),
    .stage_ready_i (stage_ready),
    .stage_rst_o   (stage_rst),
    .seq_done_o    (seq_done),
    .lock_err_o    (lock_err),
    .retry_cnt_o   (retry_cnt),
    .state_o       (state)
  );

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic [2:0] st;
    logic       done;
    logic       err;
    logic [7:0] retry;
  } exp_t;

  exp_t exp_q[$];
  exp_t pwr_tbl[14];
  int   cyc;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t mk(input int c, input logic [3:0] r, input logic [2:0] s,
                              input logic d, input logic e, input logic [7:0] rc);
    exp_t x;
    x.cyc = c; x.rst = r; x.st = s; x.done = d; x.err = e; x.retry = rc;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, req);
  endtask

  task automatic sb_check(input string nm);
    exp_t x;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      cmp({nm, ".stage_rst"}, 8'(stage_rst), 8'(x.rst));
      cmp({nm, ".state"},     8'(state),     8'(x.st));
      cmp({nm, ".seq_done"},  8'(seq_done),  8'(x.done));
      cmp({nm, ".lock_err"},  8'(lock_err),  8'(x.err));
      cmp({nm, ".retry_cnt"}, retry_cnt,     x.retry);
    end
  endtask

  task automatic exp_now(input string nm, input exp_t v);
    exp_q.push_back(v);
    sb_check(nm);
  endtask

  task automatic exp_at(input string nm, input exp_t v);
    goto_cyc(v.cyc);
    exp_q.push_back(v);
    sb_check(nm);
  endtask

  task automatic do_reset(input logic lock);
    pll_locked = lock;
    sw_rst_req = 1'b0;
    async_rst  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    async_rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up with lock held high and immediate acks: stage k released at 24+9k.
    pwr_tbl[0]  = mk(0,  4'hF, SH, 1'b0, 1'b0, 8'd0);
    pwr_tbl[1]  = mk(15, 4'hF, SH, 1'b0, 1'b0, 8'd0);
    pwr_tbl[2]  = mk(16, 4'hF, SW, 1'b0, 1'b0, 8'd0);
    pwr_tbl[3]  = mk(23, 4'hF, SW, 1'b0, 1'b0, 8'd0);
    pwr_tbl[4]  = mk(24, 4'hE, SR, 1'b0, 1'b0, 8'd0);
    pwr_tbl[5]  = mk(25, 4'hE, SG, 1'b0, 1'b0, 8'd0);
    pwr_tbl[6]  = mk(32, 4'hE, SG, 1'b0, 1'b0, 8'd0);
    pwr_tbl[7]  = mk(33, 4'hC, SR, 1'b0, 1'b0, 8'd0);
    pwr_tbl[8]  = mk(42, 4'h8, SR, 1'b0, 1'b0, 8'd0);
    pwr_tbl[9]  = mk(51, 4'h0, SR, 1'b0, 1'b0, 8'd0);
    pwr_tbl[10] = mk(52, 4'h0, SG, 1'b0, 1'b0, 8'd0);
    pwr_tbl[11] = mk(59, 4'h0, SG, 1'b0, 1'b0, 8'd0);
    pwr_tbl[12] = mk(60, 4'h0, SN, 1'b1, 1'b0, 8'd0);
    pwr_tbl[13] = mk(70, 4'h0, SN, 1'b1, 1'b0, 8'd0);

    ready_en = 4'hF;
    do_reset(1'b1);
    for (int i = 0; i < 14; i++) exp_at($sformatf("pwr%0d", i), pwr_tbl[i]);

    // Lock drops for 3 cycles in RUN; sync latency puts the abort at cycle 73.
    pll_locked = 1'b0;
    exp_at("loss_pre",   mk(72,  4'h0, SN, 1'b1, 1'b0, 8'd0));
    exp_at("loss_hold",  mk(73,  4'hF, SH, 1'b0, 1'b0, 8'd1));
    pll_locked = 1'b1;
    exp_at("loss_wait",  mk(96,  4'hF, SW, 1'b0, 1'b0, 8'd1));
    exp_at("loss_rel0",  mk(97,  4'hE, SR, 1'b0, 1'b0, 8'd1));
    exp_at("loss_run",   mk(133, 4'h0, SN, 1'b1, 1'b0, 8'd1));

    // Software request while stage 2 is waiting for its ack, then one during HOLD.
    ready_en = 4'b1011;
    do_reset(1'b1);
    exp_at("sw_rel2",    mk(44, 4'h8, SR, 1'b0, 1'b0, 8'd0));
    goto_cyc(45);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    exp_now("sw_hold",   mk(46, 4'hF, SH, 1'b0, 1'b0, 8'd0));
    goto_cyc(50);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    exp_at("sw_hold_end", mk(61, 4'hF, SH, 1'b0, 1'b0, 8'd0));
    exp_at("sw_wait",     mk(62, 4'hF, SW, 1'b0, 1'b0, 8'd0));
    exp_at("sw_rel0",     mk(70, 4'hE, SR, 1'b0, 1'b0, 8'd0));

    // Stage 1 never acknowledges: stall in RELEASE(1), then async reset mid-wait.
    ready_en = 4'b1101;
    do_reset(1'b1);
    exp_at("stall_rel1",  mk(33,  4'hC, SR, 1'b0, 1'b0, 8'd0));
    exp_at("stall_late",  mk(300, 4'hC, SR, 1'b0, 1'b0, 8'd0));
    #3;
    async_rst = 1'b1;
    #1;
    exp_now("stall_arst", mk(300, 4'hF, SH, 1'b0, 1'b0, 8'd0));

    // Lock glitch in WAIT_LOCK: lock_s high 16..20, low 21, high from 22.
    ready_en = 4'hF;
    do_reset(1'b0);
    goto_cyc(14);
    pll_locked = 1'b1;
    goto_cyc(19);
    pll_locked = 1'b0;
    goto_cyc(20);
    pll_locked = 1'b1;
    exp_at("glitch_24",  mk(24, 4'hF, SW, 1'b0, 1'b0, 8'd0));
    exp_at("glitch_29",  mk(29, 4'hF, SW, 1'b0, 1'b0, 8'd0));
    exp_at("glitch_rel", mk(30, 4'hE, SR, 1'b0, 1'b0, 8'd0));

    // Lock never arrives: two consecutive timeouts.
    do_reset(1'b0);
    exp_at("to1_pre",  mk(1039, 4'hF, SW, 1'b0, 1'b0, 8'd0));
    exp_at("to1",      mk(1040, 4'hF, SH, 1'b0, 1'b1, 8'd1));
    exp_at("to2_pre",  mk(2079, 4'hF, SW, 1'b0, 1'b1, 8'd1));
    exp_at("to2",      mk(2080, 4'hF, SH, 1'b0, 1'b1, 8'd2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
